// File: rtl/prom_access_arbiter_if.sv
// Bundles the two requester channels, the shared response and the PROM pins.
// The arbiter connects through the slave modport; the requesters and the PROM connect through master.
interface prom_access_arbiter_if #(
   parameter int AW = 8,
   parameter int DW = 4
);
   logic          req0;
   logic [AW-1:0] addr0;
   logic          gnt0;
   logic          rsp_valid0;
   logic          req1;
   logic [AW-1:0] addr1;
   logic          gnt1;
   logic          rsp_valid1;
   logic [DW-1:0] rsp_data;
   logic          busy;
   logic [AW-1:0] prom_a;
   logic          prom_ce1_b;
   logic          prom_ce2_b;
   logic [DW-1:0] prom_o;

   modport slave (
      input  req0, addr0, req1, addr1, prom_o,
      output gnt0, rsp_valid0, gnt1, rsp_valid1, rsp_data, busy,
             prom_a, prom_ce1_b, prom_ce2_b
   );

   modport master (
      output req0, addr0, req1, addr1, prom_o,
      input  gnt0, rsp_valid0, gnt1, rsp_valid1, rsp_data, busy,
             prom_a, prom_ce1_b, prom_ce2_b
   );
endinterface

// File: rtl/prom_access_arbiter.sv
// Round-robin sharing of one registered 256x4 PROM between two requesters.
// Each nibble returns to its issuer exactly two cycles after the grant.
module prom_access_arbiter #(
   parameter int AW        = 8,
   parameter int DW        = 4,
   parameter int INIT_WAIT = 4
) (
   input logic                  clk,
   input logic                  reset,
   prom_access_arbiter_if.slave bus
);
   typedef enum logic {S_INIT, S_RUN} state_t;

   localparam int CW = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(INIT_WAIT - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          last_q, last_d;
   logic          s1_vld_q, s1_vld_d;
   logic          s1_id_q, s1_id_d;
   logic          s2_vld_q, s2_vld_d;
   logic          s2_id_q, s2_id_d;
   logic [DW-1:0] rsp_data_q, rsp_data_d;
   logic          gnt0, gnt1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_INIT;
         cnt_q      <= '0;
         last_q     <= 1'b1;
         s1_vld_q   <= 1'b0;
         s1_id_q    <= 1'b0;
         s2_vld_q   <= 1'b0;
         s2_id_q    <= 1'b0;
         rsp_data_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         s1_vld_q   <= s1_vld_d;
         s1_id_q    <= s1_id_d;
         s2_vld_q   <= s2_vld_d;
         s2_id_q    <= s2_id_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      if (state_q == S_INIT) begin
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == CNT_LAST) state_d = S_RUN;
      end else if (!reset) begin
         // last_q==1 means requester 1 won most recently, so 0 takes a tie
         if (bus.req0 && (!bus.req1 || last_q)) gnt0 = 1'b1;
         else if (bus.req1)                      gnt1 = 1'b1;
      end
      if (gnt0) last_d = 1'b0;
      if (gnt1) last_d = 1'b1;

      s1_vld_d   = gnt0 | gnt1;
      s1_id_d    = gnt1;
      s2_vld_d   = s1_vld_q;
      s2_id_d    = s1_id_q;
      rsp_data_d = s1_vld_q ? bus.prom_o : rsp_data_q;
   end

   assign bus.gnt0       = gnt0;
   assign bus.gnt1       = gnt1;
   assign bus.prom_a     = gnt0 ? bus.addr0 : (gnt1 ? bus.addr1 : '0);
   assign bus.prom_ce1_b = ~(gnt0 | gnt1);
   assign bus.prom_ce2_b = ~(gnt0 | gnt1);
   // Gating with reset drops responses already due in the reset cycle itself
   assign bus.rsp_valid0 = s2_vld_q & ~s2_id_q & ~reset;
   assign bus.rsp_valid1 = s2_vld_q &  s2_id_q & ~reset;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.busy       = (state_q == S_INIT) | reset;
endmodule
